// File: rtl/cache_axi_pkg.sv
// ============================================================================
// cache_axi_pkg: shared FSM encodings and AXI constants for the store path.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_axi_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_e;

  typedef enum logic {
    SRC_LINE = 1'b0,
    SRC_UNC  = 1'b1
  } src_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam int         LINE_BEATS = 4;

  // Word idx of a 128-bit line; word 0 sits in the low bits.
  function automatic logic [31:0] line_word(input logic [127:0] line, input logic [1:0] idx);
    return line[32*idx +: 32];
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_axi_write_ctrl.sv
// ============================================================================
// wb_axi_write_ctrl: drains write-buffer lines (4-beat INCR) and uncached
// single-word stores onto one AXI write port, buffer first.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_axi_write_ctrl
  import cache_axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID     = 4'd1,
  parameter int         BEAT_W     = 32,
  parameter int         LINE_BEATS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     wb_state_i,
  input  logic [31:0]                    wb_addr_i,
  input  logic [LINE_BEATS*BEAT_W-1:0]   wb_data_i,
  output logic                           wb_pop_o,
  output logic                           wb_inflight_o,
  input  logic                           unc_req_i,
  input  logic [31:0]                    unc_addr_i,
  input  logic [BEAT_W-1:0]              unc_data_i,
  input  logic [3:0]                     unc_wstrb_i,
  output logic                           unc_ack_o,
  output logic [3:0]                     awid,
  output logic [31:0]                    awaddr,
  output logic [7:0]                     awlen,
  output logic [2:0]                     awsize,
  output logic [1:0]                     awburst,
  output logic                           awvalid,
  input  logic                           awready,
  output logic [BEAT_W-1:0]              wdata,
  output logic [3:0]                     wstrb,
  output logic                           wlast,
  output logic                           wvalid,
  input  logic                           wready,
  input  logic [1:0]                     bresp,
  input  logic                           bvalid,
  output logic                           bready,
  output logic                           busy_o,
  output logic                           err_o
);

  state_e                          state_q;
  src_e                            src_q;
  logic [1:0]                      beat_q;
  logic [LINE_BEATS*BEAT_W-1:0]    line_q;
  logic [BEAT_W-1:0]               udata_q;
  logic [3:0]                      ustrb_q;

  logic [3:0]        awid_q;
  logic [31:0]       awaddr_q;
  logic [7:0]        awlen_q;
  logic [2:0]        awsize_q;
  logic [1:0]        awburst_q;
  logic              awvalid_q;
  logic [BEAT_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic              wlast_q;
  logic              wvalid_q;
  logic              bready_q;
  logic              err_q;

  // The full flag carries no sequencing information here.
  logic unused_full;
  assign unused_full = wb_state_i[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      src_q     <= SRC_LINE;
      beat_q    <= 2'd0;
      line_q    <= '0;
      udata_q   <= '0;
      ustrb_q   <= 4'h0;
      awid_q    <= 4'h0;
      awaddr_q  <= 32'h0;
      awlen_q   <= 8'h0;
      awsize_q  <= 3'h0;
      awburst_q <= 2'h0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= 4'h0;
      wlast_q   <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wb_state_i[0]) begin
            src_q     <= SRC_LINE;
            line_q    <= wb_data_i;
            awaddr_q  <= wb_addr_i;
            awlen_q   <= 8'(LINE_BEATS - 1);
            awid_q    <= AXI_ID;
            awsize_q  <= SIZE_4B;
            awburst_q <= BURST_INCR;
            awvalid_q <= 1'b1;
            state_q   <= S_ADDR;
          end else if (unc_req_i) begin
            src_q     <= SRC_UNC;
            udata_q   <= unc_data_i;
            ustrb_q   <= unc_wstrb_i;
            awaddr_q  <= {unc_addr_i[31:2], 2'b00};
            awlen_q   <= 8'h0;
            awid_q    <= AXI_ID;
            awsize_q  <= SIZE_4B;
            awburst_q <= BURST_INCR;
            awvalid_q <= 1'b1;
            state_q   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            beat_q    <= 2'd0;
            if (src_q == SRC_LINE) begin
              wdata_q <= line_word(line_q, 2'd0);
              wstrb_q <= 4'hF;
              wlast_q <= (LINE_BEATS == 1);
            end else begin
              wdata_q <= udata_q;
              wstrb_q <= ustrb_q;
              wlast_q <= 1'b1;
            end
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (wready) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              beat_q   <= 2'd0;
              bready_q <= 1'b1;
              state_q  <= S_RESP;
            end else begin
              // Preload the next word so it is on the bus the cycle after the handshake.
              beat_q  <= beat_q + 2'd1;
              wdata_q <= line_word(line_q, beat_q + 2'd1);
              wlast_q <= ((beat_q + 2'd1) == 2'(LINE_BEATS - 1));
            end
          end
        end
        S_RESP: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            if (bresp != RESP_OKAY) err_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Retire pulses coincide with the B handshake; the FSM is back in IDLE a cycle later.
  assign wb_pop_o      = bready_q && bvalid && (src_q == SRC_LINE);
  assign unc_ack_o     = bready_q && bvalid && (src_q == SRC_UNC);
  assign busy_o        = (state_q != S_IDLE);
  assign wb_inflight_o = busy_o && (src_q == SRC_LINE);

  assign awid    = awid_q;
  assign awaddr  = awaddr_q;
  assign awlen   = awlen_q;
  assign awsize  = awsize_q;
  assign awburst = awburst_q;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = wlast_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;
  assign err_o   = err_q;

endmodule

`default_nettype wire

// File: doc/wb_axi_write_ctrl.md
Name: wb_axi_write_ctrl

Overview:
Sequences the drain of the 2-entry write buffer onto the AXI write channels and shares those channels between buffered line writes and uncached single-word stores.
- Line writes go out as 4-beat INCR bursts of 32 bits.
- Uncached stores go out as single-beat writes.
- Store ordering is preserved: an uncached store is issued only when the write buffer is empty and no transaction is in flight.
- Sits between the data-cache store path (write buffer + uncached path) and the AXI interconnect.

Parameters:
AXI_ID, 4'd1, AWID driven on every write.
BEAT_W, 32, AXI data width; fixed at 32.
LINE_BEATS, 4, beats per buffered line (128/BEAT_W).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
wb_state_i  in  2  write-buffer state {full, working}; working=1 means the head entry is valid
wb_addr_i  in  32  head line address, 16-byte aligned
wb_data_i  in  128  head line data; bits [31:0] = lowest word
wb_pop_o  out  1  one-cycle pulse; write buffer retires its head entry
wb_inflight_o  out  1  head entry captured and in flight; write buffer must not merge CPU writes into the head while this is high
unc_req_i  in  1  uncached store request, held until acked
unc_addr_i  in  32  uncached byte address
unc_data_i  in  32  uncached store data
unc_wstrb_i  in  4  uncached byte strobes
unc_ack_o  out  1  one-cycle pulse on uncached B handshake
awid/awaddr/awlen/awsize/awburst  out  4/32/8/3/2  AXI AW payload
awvalid  out  1  AXI AW valid
awready  in  1  AXI AW ready
wdata/wstrb/wlast  out  32/4/1  AXI W payload
wvalid  out  1  AXI W valid
wready  in  1  AXI W ready
bresp  in  2  AXI write response
bvalid  in  1  AXI B valid
bready  out  1  AXI B ready
busy_o  out  1  state != IDLE
err_o  out  1  sticky; set by any bresp != 2'b00

Behaviour:
- States: IDLE, ADDR, DATA, RESP. Source register `src` (LINE/UNC) and a 2-bit beat counter.
- Reset (async, rst=0): state IDLE, beat counter 0, err_o 0; every valid/ready/pulse output 0, all payload outputs 0.
- IDLE selection, evaluated every cycle:
  - If wb_state_i[0]=1: capture wb_addr_i and wb_data_i into internal registers, src=LINE, go to ADDR.
  - Else if unc_req_i=1: capture addr/data/strobes, src=UNC, go to ADDR.
  - The write buffer has strict priority; an uncached store waits until the buffer is empty.
- ADDR:
  - awvalid=1; awid=AXI_ID; awburst=2'b01; awsize=3'b010.
  - LINE: awaddr = captured line address, awlen=3.
  - UNC: awaddr = unc address with bits [1:0] cleared, awlen=0.
  - Payload is stable while awvalid=1 and awready=0.
  - On awready go to DATA.
- DATA:
  - wvalid=1.
  - LINE: wdata = captured word[beat]; wstrb=4'hF; wlast = (beat==3).
  - UNC: wdata = captured data; wstrb = captured strobes; wlast=1.
  - Beat counter advances only on wvalid&wready.
  - On the last-beat handshake, clear the counter and go to RESP.
  - Back-pressure of any length holds the current beat unchanged.
- RESP:
  - bready=1.
  - On bvalid: LINE pulses wb_pop_o; UNC pulses unc_ack_o; both pulse in the same cycle as the handshake, then return to IDLE.
  - If bresp != 0, set err_o; the transaction still completes (no retry).
- wb_inflight_o = 1 from the cycle after capture of a LINE through the wb_pop_o cycle inclusive.
- Earliest possible line transaction: IDLE capture, 1 AW cycle, 4 W cycles, 1 B cycle. Back-to-back lines have 1 IDLE cycle between them.
- A new selection is never made in the cycle wb_pop_o pulses. The buffer head updates first, and IDLE samples wb_state_i on the next cycle.
- Simultaneous wb working and unc_req_i in IDLE: LINE wins; unc_req_i stays pending.
- Full buffer (wb_state_i=2'b11) behaves the same as working; full is informational only.
- Reset asserted mid-transaction: abort immediately to IDLE, no pop and no ack. The interconnect is reset in the same domain.
- awvalid, wvalid and bready never deassert before their handshake completes.

Decomposition:
- Shared package (cache_axi_pkg): state encoding, AXI burst/size/resp constants (BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY=2'b00), LINE_BEATS.
- No sub-module; a single FSM plus capture registers. Beat selection is a 4:1 mux on the captured line.

Test Plan:
- Single line, ready always high: wb_state_i=01, addr 0x1000_0040, data 0x44443333_22221111_... → AW awaddr=0x10000040 awlen=3; W beats 0x1111.. to 0x4444.., wlast on beat 3; wb_pop_o pulses exactly once.
- Uncached store while idle: addr 0xBFD0_0003, data 0x000000AB, strb 4'b1000 → awaddr=0xBFD00000, awlen=0, one W beat with wlast=1 and wstrb=1000; unc_ack_o pulses; wb_pop_o never pulses.
- Contention: wb_state_i=01 and unc_req_i=1 in the same cycle → line issued first; the uncached AW appears only after wb_pop_o and after wb_state_i drops to 00.
- Back-pressure: wready toggling 1 of every 3 cycles and awready delayed 5 cycles → payload stable while stalled; exactly 4 W handshakes; beat order preserved.
- Error response: bresp=2'b10 on a line write → err_o=1 and stays set; wb_pop_o still pulses; the next transaction proceeds normally.
- Reset during DATA after beat 1 → all valids 0 immediately; state IDLE; no pop; the line is reissued from beat 0 after reset release.
